// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on input and output,
// holding one result plus status flags until the consumer takes it.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             c_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,
                           OP_OR  = 4'd3,  OP_XOR = 4'd4,  OP_NOT = 4'd5,
                           OP_SHL = 4'd6,  OP_SHR = 4'd7,  OP_ROL = 4'd8,
                           OP_ROR = 4'd9,  OP_ADC = 4'd10, OP_MUL = 4'd11;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    state_t r_state, w_next;

    logic [WIDTH-1:0]   r_y, r_yhi;
    logic               r_cout, r_zero, r_neg, r_ovf, r_err;
    logic [2*WIDTH-1:0] r_acc, r_mcand, w_acc_next;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHW-1:0]     r_step;

    logic               w_accept, w_load_single, w_start_mul, w_last, w_cin;
    logic [SHW-1:0]     w_sh;
    logic [SHW:0]       w_inv;
    logic [WIDTH:0]     w_sum, w_diff, w_shl, w_shr;
    logic [WIDTH-1:0]   w_rol, w_ror, w_res;
    logic               w_cout, w_ovf, w_err;

    // The carry register doubles as the ADC carry-in flag.
    assign w_cin  = (sel == OP_ADC) & r_cout;
    assign w_sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, w_cin};
    assign w_diff = {1'b0, A} - {1'b0, B};
    assign w_sh   = B[SHW-1:0];
    assign w_inv  = (SHW+1)'(WIDTH) - {1'b0, w_sh};
    assign w_shl  = {1'b0, A} << w_sh;
    assign w_shr  = {A, 1'b0} >> w_sh;
    assign w_rol  = (A << w_sh) | (A >> w_inv);
    assign w_ror  = (A >> w_sh) | (A << w_inv);

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        w_err  = 1'b0;
        case (sel)
            OP_ADD, OP_ADC: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_res  = w_diff[WIDTH-1:0];
                w_cout = w_diff[WIDTH];
                w_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: w_res = A & B;
            OP_OR:  w_res = A | B;
            OP_XOR: w_res = A ^ B;
            OP_NOT: w_res = ~A;
            OP_SHL: begin
                w_res  = w_shl[WIDTH-1:0];
                w_cout = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res  = w_shr[WIDTH:1];
                w_cout = w_shr[0];
            end
            OP_ROL: begin
                w_res  = w_rol;
                w_cout = (w_sh != '0) & w_rol[0];
            end
            OP_ROR: begin
                w_res  = w_ror;
                w_cout = (w_sh != '0) & w_ror[WIDTH-1];
            end
            OP_MUL:  w_err = 1'b0;
            default: w_err = 1'b1;
        endcase
    end

    assign w_accept      = in_valid & in_ready;
    assign w_load_single = w_accept & (sel != OP_MUL);
    assign w_start_mul   = w_accept & (sel == OP_MUL);
    assign w_last        = (r_state == BUSY) && (r_step == SHW'(WIDTH-1));
    assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (sel == OP_MUL) w_next = BUSY;
                    else               w_next = HOLD;
                end
            end
            BUSY: if (w_last) w_next = HOLD;
            HOLD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (!in_valid)          w_next = IDLE;
                    else if (sel == OP_MUL) w_next = BUSY;
                    else                    w_next = HOLD;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Result registers and the shift-add multiplier, one partial product per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y      <= '0;
            r_yhi    <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_step   <= '0;
        end else if (w_load_single) begin
            r_y    <= w_res;
            r_yhi  <= '0;
            r_cout <= w_cout;
            r_zero <= (w_res == '0);
            r_neg  <= w_res[WIDTH-1];
            r_ovf  <= w_ovf;
            r_err  <= w_err;
        end else if (w_start_mul) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= B;
            r_step   <= '0;
        end else if (r_state == BUSY) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_step   <= r_step + SHW'(1);
            if (w_last) begin
                r_y    <= w_acc_next[WIDTH-1:0];
                r_yhi  <= w_acc_next[2*WIDTH-1:WIDTH];
                r_cout <= 1'b0;
                r_zero <= (w_acc_next == '0);
                r_neg  <= w_acc_next[2*WIDTH-1];
                r_ovf  <= 1'b0;
                r_err  <= 1'b0;
            end
        end
    end

    assign y         = r_y;
    assign y_hi      = r_yhi;
    assign c_out     = r_cout;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign ovf       = r_ovf;
    assign err       = r_err;
    assign out_valid = (r_state == HOLD);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=8) against a
// behavioural reference model.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] A = '0, B = '0;
    logic [3:0] sel = '0;
    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic       in_ready, c_out, zero, neg, ovf, err, out_valid;
    logic [7:0] y, y_hi;

    int  nChecks = 0;
    int  nErrors = 0;
    logic mCflag = 1'b0;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] yhi;
        logic c, z, n, o, e;
    } res_t;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .y_hi(y_hi), .c_out(c_out), .zero(zero), .neg(neg),
        .ovf(ovf), .err(err), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference behaviour written from the opcode rules with plain arithmetic.
    function automatic res_t model(input logic [3:0] s, input logic [7:0] a,
                                   input logic [7:0] b, input logic cf);
        res_t r;
        int sh, full;
        logic [7:0] t;
        logic [15:0] p;
        r = '0; sh = int'(b) % 8; full = 0; t = a; p = '0;
        case (s)
            4'd0, 4'd10: begin
                full = int'(a) + int'(b) + ((s == 4'd10 && cf) ? 1 : 0);
                r.y = full[7:0]; r.c = full > 255;
                r.o = (a[7] == b[7]) && (r.y[7] != a[7]);
            end
            4'd1: begin
                full = int'(a) - int'(b);
                r.y = full[7:0]; r.c = a < b;
                r.o = (a[7] != b[7]) && (r.y[7] != a[7]);
            end
            4'd2: r.y = a & b;
            4'd3: r.y = a | b;
            4'd4: r.y = a ^ b;
            4'd5: r.y = ~a;
            4'd6: begin full = int'(a) << sh; r.y = full[7:0]; r.c = full[8]; end
            4'd7: begin
                full = (int'(a) << 1) >> sh;
                r.y = full[8:1]; r.c = full[0];
            end
            4'd8: begin
                for (int k = 0; k < sh; k++) t = {t[6:0], t[7]};
                r.y = t; r.c = (sh > 0) && t[0];
            end
            4'd9: begin
                for (int k = 0; k < sh; k++) t = {t[0], t[7:1]};
                r.y = t; r.c = (sh > 0) && t[7];
            end
            4'd11: begin p = 16'(a) * 16'(b); r.y = p[7:0]; r.yhi = p[15:8]; end
            default: r.e = 1'b1;
        endcase
        r.z = (r.y == 8'h00) && (r.yhi == 8'h00);
        r.n = (s == 4'd11) ? r.yhi[7] : r.y[7];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkResult(input string tag, input res_t e);
        checkOutput({tag, ".y"},    32'(y),         32'(e.y));
        checkOutput({tag, ".yhi"},  32'(y_hi),      32'(e.yhi));
        checkOutput({tag, ".c"},    32'(c_out),     32'(e.c));
        checkOutput({tag, ".z"},    32'(zero),      32'(e.z));
        checkOutput({tag, ".n"},    32'(neg),       32'(e.n));
        checkOutput({tag, ".ovf"},  32'(ovf),       32'(e.o));
        checkOutput({tag, ".err"},  32'(err),       32'(e.e));
        checkOutput({tag, ".oval"}, 32'(out_valid), 32'd1);
    endtask

    // Present one op and return just after the edge that accepted it.
    task automatic applyStimulus(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1; sel = s; A = a; B = b;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom); sel = 4'($urandom);
    endtask

    task automatic waitResult(output int lat, output int busy);
        lat = 0; busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!in_ready && !out_valid) busy++;
        end while (!out_valid && lat < 100);
    endtask

    task automatic runOp(input string tag, input logic [3:0] s, input logic [7:0] a,
                         input logic [7:0] b, input bit holdOut, output res_t e);
        int lat, busy;
        e = model(s, a, b, mCflag);
        applyStimulus(s, a, b);
        out_ready = !holdOut;
        waitResult(lat, busy);
        mCflag = e.c;
        checkOutput({tag, ".lat"}, 32'(lat), (s == 4'd11) ? 32'd9 : 32'd1);
        if (s == 4'd11) checkOutput({tag, ".busy"}, 32'(busy), 32'd8);
        checkResult(tag, e);
    endtask

    initial begin
        res_t e, held;
        int hold;
        logic sawValid;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst.y", 32'(y), 32'd0);
        checkOutput("rst.yhi", 32'(y_hi), 32'd0);
        checkOutput("rst.flags", 32'({c_out, zero, neg, ovf, err}), 32'd0);
        checkOutput("rst.oval", 32'(out_valid), 32'd0);
        checkOutput("rst.irdy", 32'(in_ready), 32'd1);

        runOp("add", 4'd0, 8'hF0, 8'h20, 1'b0, e);
        checkOutput("add.plan", 32'({y, c_out, ovf, zero}), 32'({8'h10, 3'b100}));
        runOp("adc", 4'd10, 8'h01, 8'h01, 1'b0, e);
        checkOutput("adc.plan", 32'(y), 32'h03);
        runOp("sub1", 4'd1, 8'h80, 8'h01, 1'b0, e);
        checkOutput("sub1.plan", 32'({y, c_out, ovf, neg}), 32'({8'h7F, 3'b010}));
        runOp("sub2", 4'd1, 8'h03, 8'h05, 1'b0, e);
        checkOutput("sub2.plan", 32'({y, c_out, neg}), 32'({8'hFE, 2'b11}));
        runOp("shl", 4'd6, 8'h81, 8'h01, 1'b0, e);
        checkOutput("shl.plan", 32'({y, c_out}), 32'({8'h02, 1'b1}));
        runOp("ror", 4'd9, 8'h01, 8'h01, 1'b0, e);
        checkOutput("ror.plan", 32'({y, c_out}), 32'({8'h80, 1'b1}));
        runOp("shr0", 4'd7, 8'h10, 8'h08, 1'b0, e);
        checkOutput("shr0.plan", 32'({y, c_out}), 32'({8'h10, 1'b0}));
        runOp("mul", 4'd11, 8'hFF, 8'hFF, 1'b0, e);
        checkOutput("mul.plan", 32'({y_hi, y}), 32'hFE01);

        // Reset in the fourth cycle of a multiply must discard it.
        applyStimulus(4'd11, 8'h0F, 8'h0D);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mCflag = 1'b0;
        sawValid = 1'b0;
        repeat (12) begin @(negedge clk); sawValid |= out_valid; end
        checkOutput("abort.oval", 32'(sawValid), 32'd0);
        checkOutput("abort.out", 32'({y_hi, y, c_out, zero, neg, ovf, err}), 32'd0);
        checkOutput("abort.irdy", 32'(in_ready), 32'd1);

        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; sel = 4'd0; A = 8'h05; B = 8'h06;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstvalid.oval", 32'(out_valid), 32'd0);
        checkOutput("rstvalid.y", 32'(y), 32'd0);

        // Backpressure with a queued XOR.
        runOp("bp", 4'd0, 8'h12, 8'h34, 1'b1, held);
        in_valid = 1'b1; sel = 4'd4; A = 8'hAA; B = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp.y", 32'(y), 32'(held.y));
            checkOutput("bp.flags", 32'({c_out, zero, neg, ovf, err}),
                        32'({held.c, held.z, held.n, held.o, held.e}));
            checkOutput("bp.irdy", 32'(in_ready), 32'd0);
        end
        e = model(4'd4, 8'hAA, 8'hFF, mCflag);
        out_ready = 1'b1;
        #1 checkOutput("bp.irdy_on", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; mCflag = e.c;
        @(negedge clk);
        checkResult("bp.xor", e);
        checkOutput("bp.xor.plan", 32'(y), 32'h55);

        runOp("rsv", 4'd13, 8'h12, 8'h34, 1'b0, e);
        checkOutput("rsv.plan", 32'({err, y, zero}), 32'({1'b1, 8'h00, 1'b1}));
        runOp("rsvclr", 4'd2, 8'h0F, 8'h3C, 1'b0, e);
        checkOutput("rsvclr.err", 32'(err), 32'd0);

        for (int i = 0; i < 60; i++) begin
            hold = $urandom_range(0, 2);
            runOp("rnd", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), hold != 0, e);
            for (int k = 0; k < hold; k++) begin
                A = 8'($urandom); B = 8'($urandom);
                @(negedge clk);
                checkOutput("rnd.hold.y", 32'({y_hi, y}), 32'({e.yhi, e.y}));
                checkOutput("rnd.hold.irdy", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
